ldm_stm_sequencer: RTL

- Parametrised multi-register transfer sequencer for LDM/STM, all four addressing modes (IA/IB/DA/DB).
- Walks the register list from lowest index to highest and issues one memory word access per register, handshaked on MOC.
- Drives register-file read/write strobes and optional base writeback.
- Sits between the control unit and the memory interface; the control unit hands over IR and Base, then waits for Done or Abort.

---
 rtl/ldm_stm_pkg.sv | 32 +++
 rtl/reg_list_scan.sv | 25 ++
 rtl/ldm_stm_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM multi-register sequencer.
package ldm_stm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        WB,
        DONE
    } state_t;

    // Addressing modes, indexed by {P,U}
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

    // Instruction word bit positions
    localparam int L_BIT = 20;
    localparam int W_BIT = 21;
    localparam int U_BIT = 23;
    localparam int P_BIT = 24;

    // Control bits captured from IR when a transfer is accepted
    typedef struct packed {
        logic p;
        logic u;
        logic w;
        logic l;
    } ctrl_t;

endpackage

// File: rtl/reg_list_scan.sv
// Combinational scan of a register list: lowest set index, any-set flag, popcount.
module reg_list_scan #(
    parameter int NREGS = 16,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic [NREGS-1:0] list,
    output logic [IDX_W-1:0] low_idx,
    output logic             any_set,
    output logic [IDX_W:0]   pop_cnt
);

    // Priority scan from the top down so the lowest set bit is the last writer
    always_comb begin
        low_idx = '0;
        pop_cnt = '0;
        any_set = |list;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (list[i]) low_idx = IDX_W'(i);
        end
        for (int i = 0; i < NREGS; i++) begin
            pop_cnt = pop_cnt + (IDX_W + 1)'(list[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the latched register list low-to-high, issuing one
// MOC-handshaked word access per register, with optional base writeback.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int NREGS       = 16,
    parameter int ADDR_W      = 32,
    parameter int IDX_W       = 4,
    parameter int WORD_BYTES  = 4,
    parameter int MOC_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] Base,
    input  logic              MOC,
    output logic              MemEn,
    output logic              MemRW,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [IDX_W-1:0]  RegIdx,
    output logic              RegRdEn,
    output logic              RegWrEn,
    output logic              WbEn,
    output logic [ADDR_W-1:0] WbValue,
    output logic              Busy,
    output logic              Done,
    output logic              Abort
);

    // Counter only needs to reach MOC_TIMEOUT-1: abort fires in the cycle
    // that would make it MOC_TIMEOUT.
    localparam int                CNT_W   = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((MOC_TIMEOUT > 0) ? MOC_TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(WORD_BYTES);

    state_t             state_q, state_d;
    ctrl_t              ctrl_q;
    logic [NREGS-1:0]   list_q;
    logic [ADDR_W-1:0]  base_q, addr_q, wb_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   low_idx;
    logic               any_set;
    logic [IDX_W:0]     pop_cnt;
    logic [NREGS-1:0]   list_rem;
    logic [ADDR_W-1:0]  span, start_addr, wb_calc;
    logic               timeout_hit;

    logic unused_ir;
    assign unused_ir = ^IR;

    reg_list_scan #(.NREGS(NREGS), .IDX_W(IDX_W)) u_scan (
        .list    (list_q),
        .low_idx (low_idx),
        .any_set (any_set),
        .pop_cnt (pop_cnt)
    );

    assign list_rem    = list_q & ~(NREGS'(1) << low_idx);
    assign timeout_hit = (MOC_TIMEOUT != 0) && (cnt_q == TO_LAST);

    // First-transfer address and writeback value from the latched base and count
    always_comb begin
        span       = ADDR_W'(pop_cnt) * STRIDE;
        start_addr = base_q - span;
        case ({ctrl_q.p, ctrl_q.u})
            MODE_IA: start_addr = base_q;
            MODE_IB: start_addr = base_q + STRIDE;
            MODE_DA: start_addr = base_q - span + STRIDE;
            default: start_addr = base_q - span;
        endcase
        wb_calc = ctrl_q.u ? (base_q + span) : (base_q - span);
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath: request latch, address walk, list consumption, MOC wait counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl_q <= '0;
            list_q <= '0;
            base_q <= '0;
            addr_q <= '0;
            wb_q   <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (Start) begin
                        ctrl_q <= '{p: IR[P_BIT], u: IR[U_BIT], w: IR[W_BIT], l: IR[L_BIT]};
                        list_q <= IR[NREGS-1:0];
                        base_q <= Base;
                    end
                end
                SETUP: begin
                    addr_q <= start_addr;
                    wb_q   <= wb_calc;
                    cnt_q  <= '0;
                end
                XFER: begin
                    if (MOC) begin
                        list_q <= list_rem;
                        addr_q <= addr_q + STRIDE;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Next state and outputs; everything idles at zero outside its own state
    always_comb begin
        state_d = state_q;
        MemEn   = 1'b0;
        MemRW   = 1'b0;
        MemAddr = '0;
        RegIdx  = '0;
        RegRdEn = 1'b0;
        RegWrEn = 1'b0;
        WbEn    = 1'b0;
        WbValue = '0;
        Done    = 1'b0;
        Abort   = 1'b0;
        Busy    = (state_q != IDLE);
        case (state_q)
            IDLE:  if (Start) state_d = SETUP;
            SETUP: state_d = any_set ? XFER : DONE;
            XFER: begin
                MemEn   = 1'b1;
                MemRW   = ctrl_q.l;
                MemAddr = addr_q;
                RegIdx  = low_idx;
                RegRdEn = !ctrl_q.l;
                if (MOC) begin
                    RegWrEn = ctrl_q.l;
                    if (!(|list_rem)) state_d = ctrl_q.w ? WB : DONE;
                end else if (timeout_hit) begin
                    Abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                WbEn    = 1'b1;
                WbValue = wb_q;
                state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
